// File: rtl/rom_access_arbiter_if.sv
// Bus bundle between the requesters/ROM (master side) and rom_access_arbiter (slave side).
// The master modport covers the environment: address generators plus the ROM data return.
interface rom_access_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ROM_DEPTH = 16
);
  localparam int IDX_W = $clog2(ROM_DEPTH);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      rom_en;
  logic [IDX_W-1:0]          rom_addr;
  logic [DATA_W-1:0]         rom_data;

  modport master (
    output req_valid, req_addr, rom_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rom_en, rom_addr
  );

  modport slave (
    input  req_valid, req_addr, rom_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, rom_en, rom_addr
  );
endinterface

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port ROM between NUM_REQ requesters.
// Optional range check enabled by defining ROM_ARB_BOUNDS_CHECK_EN.
module rom_access_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ROM_DEPTH   = 16,
  parameter int ROM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  rom_access_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(ROM_DEPTH);
  localparam int GNT_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [GNT_W-1:0]   gnt_q, gnt_d;
  logic [GNT_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic [IDX_W-1:0]   req_idx [NUM_REQ];
  logic               found;
  logic [GNT_W-1:0]   pick;
  logic [GNT_W-1:0]   cand;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_idx
      assign req_idx[gi] = bus.req_addr[gi*ADDR_W+2 +: IDX_W];
    end
  endgenerate

`ifdef ROM_ARB_BOUNDS_CHECK_EN
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] req_oob;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_oob
      assign req_oob[gi] = {1'b0, bus.req_addr[gi*ADDR_W +: ADDR_W]} >= (ADDR_W+1)'(ROM_DEPTH*4);
    end
  endgenerate
`endif

  // Rotating priority: search starts just after the previous winner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GNT_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= GNT_W'(NUM_REQ-1);
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

`ifdef ROM_ARB_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
`ifdef ROM_ARB_BOUNDS_CHECK_EN
    err_d     = err_q;
`endif
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[pick] = 1'b1;
          gnt_d           = pick;
          last_d          = pick;
          idx_d           = req_idx[pick];
          state_d         = ISSUE;
`ifdef ROM_ARB_BOUNDS_CHECK_EN
          // Out-of-range reads never touch the ROM; answer with an error instead.
          if (req_oob[pick]) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
`endif
        end
      end
      ISSUE: begin
        cnt_d   = 2'(ROM_LATENCY-1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          data_d  = bus.rom_data;
`ifdef ROM_ARB_BOUNDS_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = data_q;
  assign bus.rom_en    = (state_q == ISSUE);
  assign bus.rom_addr  = idx_q;
`ifdef ROM_ARB_BOUNDS_CHECK_EN
  assign bus.rsp_err   = err_q & (state_q == RESP);
`else
  assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: one instance at ROM_LATENCY=1, one at ROM_LATENCY=3,
// each with its own ROM model that returns a poison word outside the valid data window.
module tb_rom_access_arbiter;
  logic clk;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] POISON = 32'hDEAD_BEEF;

  rom_access_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .ROM_DEPTH(16)) bus1 ();
  rom_access_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .ROM_DEPTH(16)) bus3 ();

  rom_access_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .ROM_DEPTH(16), .ROM_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave)
  );
  rom_access_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .ROM_DEPTH(16), .ROM_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3.slave)
  );

  function automatic logic [31:0] rom_word(input logic [3:0] i);
    return 32'hC0DE_0000 + {12'd0, i, 12'd0} + {28'd0, i};
  endfunction

  // ROM models: word is presented exactly ROM_LATENCY cycles after rom_en.
  logic [31:0] pipe1;
  logic [31:0] pipe3a, pipe3b, pipe3c;
  always @(posedge clk) begin
    pipe1  <= bus1.rom_en ? rom_word(bus1.rom_addr) : POISON;
    pipe3a <= bus3.rom_en ? rom_word(bus3.rom_addr) : POISON;
    pipe3b <= pipe3a;
    pipe3c <= pipe3b;
  end
  assign bus1.rom_data = pipe1;
  assign bus3.rom_data = pipe3c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] g;
    reset_n        = 1'b0;
    bus1.req_valid = '0;
    bus1.req_addr  = '0;
    bus3.req_valid = '0;
    bus3.req_addr  = '0;

    #2;
    chk("rst_ready",     32'(bus1.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("rst_rsp_data",  bus1.rsp_data,       32'd0);
    chk("rst_rsp_err",   32'(bus1.rsp_err),   32'd0);
    chk("rst_rom_en",    32'(bus1.rom_en),    32'd0);
    chk("rst_rom_addr",  32'(bus1.rom_addr),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Single read on req0, addr 0x24 -> word 9
    cyc(); bus1.req_addr[31:0] = 32'h24; bus1.req_valid = 2'b01; #1;
    chk("t1_ready_T",  32'(bus1.req_ready), 32'd1);
    chk("t1_rom_en_T", 32'(bus1.rom_en),    32'd0);
    cyc(); bus1.req_valid = 2'b00; bus1.req_addr[31:0] = 32'h3C; #1;
    chk("t1_rom_en_T1",   32'(bus1.rom_en),    32'd1);
    chk("t1_rom_addr_T1", 32'(bus1.rom_addr),  32'd9);
    chk("t1_ready_T1",    32'(bus1.req_ready), 32'd0);
    cyc(); #1;
    chk("t1_rom_en_T2",    32'(bus1.rom_en),    32'd0);
    chk("t1_rsp_valid_T2", 32'(bus1.rsp_valid), 32'd0);
    cyc(); #1;
    chk("t1_rsp_valid_T3", 32'(bus1.rsp_valid), 32'd1);
    chk("t1_rsp_data_T3",  bus1.rsp_data,       rom_word(4'd9));
    chk("t1_rsp_err_T3",   32'(bus1.rsp_err),   32'd0);
    cyc(); #1;
    chk("t1_rsp_valid_T4", 32'(bus1.rsp_valid), 32'd0);
    chk("t1_rsp_hold_T4",  bus1.rsp_data,       rom_word(4'd9));

    // Address 0x40: wraps to word 0, or errors when range checking is on
    cyc(); bus1.req_addr[31:0] = 32'h40; bus1.req_valid = 2'b01; #1;
    chk("t2_ready_T", 32'(bus1.req_ready), 32'd1);
    cyc(); bus1.req_valid = 2'b00; #1;
`ifdef ROM_ARB_BOUNDS_CHECK_EN
    chk("t2_rom_en_T1",    32'(bus1.rom_en),    32'd0);
    chk("t2_rsp_valid_T1", 32'(bus1.rsp_valid), 32'd1);
    chk("t2_rsp_data_T1",  bus1.rsp_data,       32'd0);
    chk("t2_rsp_err_T1",   32'(bus1.rsp_err),   32'd1);
    cyc(); #1;
    chk("t2_rsp_valid_T2", 32'(bus1.rsp_valid), 32'd0);
    chk("t2_rsp_err_T2",   32'(bus1.rsp_err),   32'd0);
`else
    chk("t2_rom_en_T1",   32'(bus1.rom_en),   32'd1);
    chk("t2_rom_addr_T1", 32'(bus1.rom_addr), 32'd0);
    cyc(); #1;
    cyc(); #1;
    chk("t2_rsp_valid_T3", 32'(bus1.rsp_valid), 32'd1);
    chk("t2_rsp_data_T3",  bus1.rsp_data,       rom_word(4'd0));
    chk("t2_rsp_err_T3",   32'(bus1.rsp_err),   32'd0);
`endif

    // Reset asserted while the transaction sits in WAIT
    cyc(); bus1.req_addr[63:32] = 32'h08; bus1.req_valid = 2'b10; #1;
    chk("t3_ready_T", 32'(bus1.req_ready), 32'd2);
    cyc(); bus1.req_valid = 2'b00; #1;
    chk("t3_rom_en_T1",   32'(bus1.rom_en),   32'd1);
    chk("t3_rom_addr_T1", 32'(bus1.rom_addr), 32'd2);
    cyc(); reset_n = 1'b0; #1;
    chk("t3_rst_rom_en",    32'(bus1.rom_en),    32'd0);
    chk("t3_rst_rom_addr",  32'(bus1.rom_addr),  32'd0);
    chk("t3_rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("t3_rst_rsp_data",  bus1.rsp_data,       32'd0);
    chk("t3_rst_rsp_err",   32'(bus1.rsp_err),   32'd0);
    chk("t3_rst_ready",     32'(bus1.req_ready), 32'd0);
    cyc(); #1;
    chk("t3_rst_hold_rsp", 32'(bus1.rsp_valid), 32'd0);
    reset_n = 1'b1;
    cyc(); #1;
    chk("t3_post_rsp_a", 32'(bus1.rsp_valid), 32'd0);
    cyc(); #1;
    chk("t3_post_rsp_b",  32'(bus1.rsp_valid), 32'd0);
    chk("t3_post_rom_en", 32'(bus1.rom_en),    32'd0);

    // Both requesters held high: grants 0,1,0,1 with a 4-cycle transaction period
    cyc(); bus1.req_addr[31:0] = 32'h04; bus1.req_addr[63:32] = 32'h0C; bus1.req_valid = 2'b11;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) cyc();
      #1;
      g = (((c / 4) % 2) != 0) ? 2'b10 : 2'b01;
      chk($sformatf("t4_ready_c%0d", c), 32'(bus1.req_ready), ((c % 4) == 0) ? 32'(g) : 32'd0);
      chk($sformatf("t4_rsp_c%0d", c),   32'(bus1.rsp_valid), ((c % 4) == 3) ? 32'(g) : 32'd0);
      chk($sformatf("t4_en_c%0d", c),    32'(bus1.rom_en),    ((c % 4) == 1) ? 32'd1 : 32'd0);
      if ((c % 4) == 3)
        chk($sformatf("t4_data_c%0d", c), bus1.rsp_data, (g == 2'b01) ? rom_word(4'd1) : rom_word(4'd3));
    end
    bus1.req_valid = 2'b00;

    // ROM_LATENCY=3: req1 addr 0x08; req0 raised after the handshake must wait
    cyc(); bus3.req_addr[63:32] = 32'h08; bus3.req_valid = 2'b10; #1;
    chk("t5_ready_T", 32'(bus3.req_ready), 32'd2);
    cyc(); bus3.req_valid = 2'b01; bus3.req_addr[31:0] = 32'h10; #1;
    chk("t5_rom_en_T1",   32'(bus3.rom_en),    32'd1);
    chk("t5_rom_addr_T1", 32'(bus3.rom_addr),  32'd2);
    chk("t5_ready_T1",    32'(bus3.req_ready), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      cyc(); #1;
      chk($sformatf("t5_rom_en_T%0d", k), 32'(bus3.rom_en),    32'd0);
      chk($sformatf("t5_ready_T%0d", k),  32'(bus3.req_ready), 32'd0);
      chk($sformatf("t5_rsp_T%0d", k),    32'(bus3.rsp_valid), 32'd0);
    end
    cyc(); #1;
    chk("t5_rsp_valid_T5", 32'(bus3.rsp_valid), 32'd2);
    chk("t5_rsp_data_T5",  bus3.rsp_data,       rom_word(4'd2));
    chk("t5_ready_T5",     32'(bus3.req_ready), 32'd0);
    cyc(); #1;
    chk("t5_ready_T6", 32'(bus3.req_ready), 32'd1);
    cyc(); bus3.req_valid = 2'b00; #1;
    chk("t5b_rom_en",   32'(bus3.rom_en),   32'd1);
    chk("t5b_rom_addr", 32'(bus3.rom_addr), 32'd4);
    repeat (4) cyc();
    #1;
    chk("t5b_rsp_valid", 32'(bus3.rsp_valid), 32'd1);
    chk("t5b_rsp_data",  bus3.rsp_data,       rom_word(4'd4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
